// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequential matrix multiplier:
//               FSM state encoding, accumulator width derivation, flat-bus
//               element offset helper and signed saturation limits.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_mac   = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // Accumulator wide enough for dim products of two signed data_w values
    function automatic int calc_acc_w(input int data_w, input int dim);
        return 2 * data_w + $clog2(dim);
    endfunction

    // Bit offset of element (r,c) in a row-major flat bus
    function automatic int elem_off(input int r, input int c, input int dim, input int data_w);
        return (r * dim + c) * data_w;
    endfunction

    // Largest representable signed data_w value
    function automatic int sat_max(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

    // Smallest representable signed data_w value
    function automatic int sat_min(input int data_w);
        return -(1 << (data_w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_mac_unit
// Description : Signed DATA_W x DATA_W multiplier feeding an ACC_W
//               accumulate register with synchronous clear and enable.
//               Clear has priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_acc_nxt;
    logic signed [ACC_W-1:0]    r_acc;

    // Full-precision product, sign-extended and added to the running sum
    always_comb begin
        w_prod    = i_a * i_b;
        w_acc_nxt = r_acc;
        if (i_clr) begin
            w_acc_nxt = '0;
        end else if (i_en) begin
            w_acc_nxt = r_acc + ACC_W'(w_prod);
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_matrix_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_matrix_mult_seq
// Description : Sequential signed square matrix multiplier C = A x B with
//               runtime size 1..DIM, one shared MAC, start/busy/done
//               handshake and per-element overflow tracking.
//               Optional macro ALU_MATMUL_SAT_EN clamps overflowing
//               elements instead of wrapping them.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_matrix_mult_seq
    import alu_pkg::*;
#(
    parameter int DIM    = 5,
    parameter int DATA_W = 8,
    parameter int ACC_W  = calc_acc_w(DATA_W, DIM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2:0]                size,
    input  logic [DIM*DIM*DATA_W-1:0] A_flat,
    input  logic [DIM*DIM*DATA_W-1:0] B_flat,
    output logic [DIM*DIM*DATA_W-1:0] C_flat,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow_flag
);

    localparam int c_flat_w = DIM * DIM * DATA_W;
    localparam int c_idx_w  = (DIM > 1) ? $clog2(DIM) : 1;

    localparam logic signed [ACC_W-1:0] c_acc_max = ACC_W'(sat_max(DATA_W));
    localparam logic signed [ACC_W-1:0] c_acc_min = ACC_W'(sat_min(DATA_W));
`ifdef ALU_MATMUL_SAT_EN
    localparam logic [DATA_W-1:0] c_dat_max = DATA_W'(sat_max(DATA_W));
    localparam logic [DATA_W-1:0] c_dat_min = DATA_W'(sat_min(DATA_W));
`endif

    // Registered state
    logic [1:0]          r_state;
    logic [c_flat_w-1:0] r_a;
    logic [c_flat_w-1:0] r_b;
    logic [c_flat_w-1:0] r_c;
    logic                r_ovf;
    logic [c_idx_w-1:0]  r_i;
    logic [c_idx_w-1:0]  r_j;
    logic [c_idx_w-1:0]  r_k;
    logic [c_idx_w-1:0]  r_last;

    // Next-state values
    logic [1:0]          w_state_nxt;
    logic [c_flat_w-1:0] w_a_nxt;
    logic [c_flat_w-1:0] w_b_nxt;
    logic [c_flat_w-1:0] w_c_nxt;
    logic                w_ovf_nxt;
    logic [c_idx_w-1:0]  w_i_nxt;
    logic [c_idx_w-1:0]  w_j_nxt;
    logic [c_idx_w-1:0]  w_k_nxt;
    logic [c_idx_w-1:0]  w_last_nxt;

    // Datapath
    logic                     w_acc_clr;
    logic                     w_acc_en;
    logic signed [DATA_W-1:0] w_a_elem;
    logic signed [DATA_W-1:0] w_b_elem;
    logic signed [ACC_W-1:0]  w_acc;
    logic                     w_elem_ovf;
    logic [DATA_W-1:0]        w_elem_val;
    logic [c_idx_w-1:0]       w_size_last;

    // Out-of-range sizes (0 or above DIM) select the full DIM; stored as size-1
    always_comb begin
        if ((size == 3'd0) || (int'(size) > DIM)) begin
            w_size_last = c_idx_w'(DIM - 1);
        end else begin
            w_size_last = c_idx_w'(int'(size) - 1);
        end
    end

    // Operand fetch: A[i][k] and B[k][j] from the latched copies
    always_comb begin
        w_a_elem = r_a[elem_off(int'(r_i), int'(r_k), DIM, DATA_W) +: DATA_W];
        w_b_elem = r_b[elem_off(int'(r_k), int'(r_j), DIM, DATA_W) +: DATA_W];
    end

    alu_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_acc_clr),
        .i_en  (w_acc_en),
        .i_a   (w_a_elem),
        .i_b   (w_b_elem),
        .o_acc (w_acc)
    );

    // Element overflow detection and the value written back to C
    always_comb begin
        w_elem_ovf = (w_acc > c_acc_max) || (w_acc < c_acc_min);
`ifdef ALU_MATMUL_SAT_EN
        if (w_acc > c_acc_max) begin
            w_elem_val = c_dat_max;
        end else if (w_acc < c_acc_min) begin
            w_elem_val = c_dat_min;
        end else begin
            w_elem_val = w_acc[DATA_W-1:0];
        end
`else
        w_elem_val = w_acc[DATA_W-1:0];
`endif
    end

    // FSM next-state, index sequencing and result write-back
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_c_nxt     = r_c;
        w_ovf_nxt   = r_ovf;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_last_nxt  = r_last;
        w_acc_clr   = 1'b0;
        w_acc_en    = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_mac;
                    w_a_nxt     = A_flat;
                    w_b_nxt     = B_flat;
                    w_last_nxt  = w_size_last;
                    w_c_nxt     = '0;
                    w_ovf_nxt   = 1'b0;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                    w_acc_clr   = 1'b1;
                end
            end

            c_st_mac: begin
                w_acc_en = 1'b1;
                if (r_k == r_last) begin
                    w_state_nxt = c_st_write;
                end else begin
                    w_k_nxt = r_k + c_idx_w'(1);
                end
            end

            c_st_write: begin
                w_c_nxt[elem_off(int'(r_i), int'(r_j), DIM, DATA_W) +: DATA_W] = w_elem_val;
                w_ovf_nxt   = r_ovf | w_elem_ovf;
                w_acc_clr   = 1'b1;
                w_k_nxt     = '0;
                w_state_nxt = c_st_mac;
                if (r_j == r_last) begin
                    w_j_nxt = '0;
                    if (r_i == r_last) begin
                        w_i_nxt     = '0;
                        w_state_nxt = c_st_done;
                    end else begin
                        w_i_nxt = r_i + c_idx_w'(1);
                    end
                end else begin
                    w_j_nxt = r_j + c_idx_w'(1);
                end
            end

            c_st_done: begin
                w_state_nxt = c_st_idle;
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_ovf   <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_c     <= w_c_nxt;
            r_ovf   <= w_ovf_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign C_flat        = r_c;
    assign busy          = (r_state != c_st_idle);
    assign done          = (r_state == c_st_done);
    assign overflow_flag = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_matrix_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_matrix_mult_seq
// Description : Directed self-checking bench for alu_matrix_mult_seq with
//               hand-computed expected matrices, latency and handshake checks.
//               Expectations follow ALU_MATMUL_SAT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_matrix_mult_seq;

    localparam int c_dim  = 5;
    localparam int c_dw   = 8;
    localparam int c_fw   = c_dim * c_dim * c_dw;

    logic            clk;
    logic            rst;
    logic            start;
    logic [2:0]      size;
    logic [c_fw-1:0] A_flat;
    logic [c_fw-1:0] B_flat;
    logic [c_fw-1:0] C_flat;
    logic            busy;
    logic            done;
    logic            overflow_flag;

    int total;
    int bad;

    int ma [c_dim][c_dim];
    int mb [c_dim][c_dim];
    int me [c_dim][c_dim];

    alu_matrix_mult_seq #(
        .DIM    (c_dim),
        .DATA_W (c_dw)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .size          (size),
        .A_flat        (A_flat),
        .B_flat        (B_flat),
        .C_flat        (C_flat),
        .busy          (busy),
        .done          (done),
        .overflow_flag (overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int get_c(input int r, input int c);
        logic signed [c_dw-1:0] v;
        v = C_flat[(r * c_dim + c) * c_dw +: c_dw];
        return int'(v);
    endfunction

    task automatic clear_mats();
        for (int r = 0; r < c_dim; r++) begin
            for (int c = 0; c < c_dim; c++) begin
                ma[r][c] = 0;
                mb[r][c] = 0;
                me[r][c] = 0;
            end
        end
    endtask

    task automatic pack();
        for (int r = 0; r < c_dim; r++) begin
            for (int c = 0; c < c_dim; c++) begin
                A_flat[(r * c_dim + c) * c_dw +: c_dw] = c_dw'(ma[r][c]);
                B_flat[(r * c_dim + c) * c_dw +: c_dw] = c_dw'(mb[r][c]);
            end
        end
    endtask

    task automatic check_mat(input string nm);
        for (int r = 0; r < c_dim; r++) begin
            for (int c = 0; c < c_dim; c++) begin
                check($sformatf("%s_c%0d%0d", nm, r, c), get_c(r, c), me[r][c]);
            end
        end
    endtask

    // mode 1: extra start pulses at edges 3 and 40, A_flat scrambled at edge 10
    task automatic run_op(input string nm, input int sz, input int lat, input int mode);
        int edges;
        int busy_lo;
        int busy_at_done;
        bit seen;
        @(negedge clk);
        size  = sz[2:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        busy_lo = 0;
        busy_at_done = 0;
        seen = 1'b0;
        while (!seen && edges < 400) begin
            @(posedge clk);
            edges++;
            #1;
            if (mode == 1) begin
                start = (edges == 3 || edges == 40);
                if (edges == 10) A_flat = '1;
            end
            if (done) begin
                seen = 1'b1;
                busy_at_done = int'(busy);
            end else if (!busy) begin
                busy_lo++;
            end
        end
        start = 1'b0;
        check({nm, "_done_seen"}, int'(seen), 1);
        check({nm, "_latency"}, edges, lat);
        check({nm, "_busy_gap"}, busy_lo, 0);
        check({nm, "_busy_at_done"}, busy_at_done, 1);
        @(posedge clk);
        #1;
        check({nm, "_done_pulse"}, int'(done), 0);
        check({nm, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int extra;
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        start  = 1'b0;
        size   = 3'd0;
        A_flat = '0;
        B_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ovf", int'(overflow_flag), 0);
        check("rst_c_zero", int'(C_flat == '0), 1);
        @(negedge clk);
        rst = 1'b0;

        // 2x2 basic product
        clear_mats();
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        me[0][0] = 19; me[0][1] = 22; me[1][0] = 43; me[1][1] = 50;
        pack();
        run_op("t1", 2, 12, 0);
        check_mat("t1");
        check("t1_ovf", int'(overflow_flag), 0);

        // 5x5 identity times patterned B
        clear_mats();
        for (int r = 0; r < c_dim; r++) begin
            ma[r][r] = 1;
            for (int c = 0; c < c_dim; c++) begin
                mb[r][c] = ((r * 37 + c * 53 + 11) % 256) - 128;
                me[r][c] = mb[r][c];
            end
        end
        pack();
        run_op("t2", 5, 150, 0);
        check_mat("t2");
        check("t2_ovf", int'(overflow_flag), 0);

        // size 0 behaves as full DIM
        run_op("t2z", 0, 150, 0);
        check_mat("t2z");

        // all 127: acc = 80645
        clear_mats();
        for (int r = 0; r < c_dim; r++) begin
            for (int c = 0; c < c_dim; c++) begin
                ma[r][c] = 127;
                mb[r][c] = 127;
`ifdef ALU_MATMUL_SAT_EN
                me[r][c] = 127;
`else
                me[r][c] = 5;
`endif
            end
        end
        pack();
        run_op("t3", 5, 150, 0);
        check_mat("t3");
        check("t3_ovf", int'(overflow_flag), 1);

        // size 2, A=-128, B=127: acc = -32512
        clear_mats();
        for (int r = 0; r < c_dim; r++) begin
            for (int c = 0; c < c_dim; c++) begin
                ma[r][c] = -128;
                mb[r][c] = 127;
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
`ifdef ALU_MATMUL_SAT_EN
                me[r][c] = -128;
`else
                me[r][c] = 0;
`endif
            end
        end
        pack();
        run_op("t4", 2, 12, 0);
        check_mat("t4");
        check("t4_ovf", int'(overflow_flag), 1);

        // start pulses during busy and operand change after acceptance
        clear_mats();
        for (int r = 0; r < c_dim; r++) begin
            ma[r][r] = 1;
            for (int c = 0; c < c_dim; c++) begin
                mb[r][c] = ((r * 19 + c * 71 + 5) % 256) - 128;
                me[r][c] = mb[r][c];
            end
        end
        pack();
        run_op("t5", 5, 150, 1);
        check_mat("t5");
        check("t5_ovf", int'(overflow_flag), 0);
        extra = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check("t5_no_queued_op", extra, 0);

        // reset in the middle of an operation
        clear_mats();
        for (int r = 0; r < c_dim; r++) begin
            for (int c = 0; c < c_dim; c++) begin
                ma[r][c] = 127;
                mb[r][c] = 127;
            end
        end
        pack();
        @(negedge clk);
        size  = 3'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t6_c_before_rst", int'(C_flat != '0), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_busy", int'(busy), 0);
        check("t6_done", int'(done), 0);
        check("t6_c_zero", int'(C_flat == '0), 1);
        extra = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("t6_no_done", extra, 0);

        // fresh 1x1 operation after the abort
        clear_mats();
        ma[0][0] = 3;
        mb[0][0] = -4;
        me[0][0] = -12;
        pack();
        run_op("t7", 1, 2, 0);
        check_mat("t7");
        check("t7_ovf", int'(overflow_flag), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_matrix_mult_seq.md
Name: alu_matrix_mult_seq

Overview:
- Sequential, parametrised successor to the combinational 5x5 int8 matrix multiplier in the coprocessor ALU.
- Computes C = A x B on signed square matrices of runtime-selectable size (1..DIM) using one shared multiply-accumulate datapath, iterating over elements.
- Sits in the ALU beside the add/sub/transpose units and is driven by the coprocessor control FSM through a start/busy/done handshake.
- Adds runtime size selection, per-element overflow tracking and optional saturation.

Parameters:
- DIM, 5, maximum matrix dimension; flat buses are DIM*DIM elements, row-major.
- DATA_W, 8, signed element width for A, B and C.
- ACC_W, 2*DATA_W+$clog2(DIM), signed accumulator width (19 at defaults); never overflows for any legal input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- size  in  3  active dimension; 1..DIM legal; 0 or >DIM is treated as DIM; latched on accepted start.
- A_flat  in  DIM*DIM*DATA_W  operand A; element (r,c) at bit offset (r*DIM+c)*DATA_W; latched on accepted start.
- B_flat  in  DIM*DIM*DATA_W  operand B; same layout; latched on accepted start.
- C_flat  out  DIM*DIM*DATA_W  result; same layout; registered.
- busy  out  1  high from the edge accepting start until the cycle done is high, inclusive.
- done  out  1  one-cycle pulse when C_flat is final.
- overflow_flag  out  1  OR of per-element overflow bits for the last operation; valid when done is high and held until the next accepted start.

Behaviour:
- Reset (synchronous) sets state IDLE and clears C_flat, busy, done, overflow_flag, indices and accumulator to 0. Reset mid-operation aborts the operation with no done pulse.
- FSM states and transitions:
  - IDLE -> MAC when start=1. That edge latches A, B and size (size rule applied), clears C_flat, overflow_flag and the accumulator, and sets i=j=k=0.
  - MAC: each cycle acc <= acc + A[i][k]*B[k][j] (signed, full precision), then k++. When k==size-1, go to WRITE.
  - WRITE: store acc into C[i][j] and record its overflow bit; set acc=0 and k=0; advance j, wrapping to 0 and incrementing i at size-1. After (size-1,size-1) go to DONE, otherwise return to MAC.
  - DONE: done=1 and busy=1 for one cycle, then go to IDLE.
- Overflow bit for an element is set when acc > 2^(DATA_W-1)-1 or acc < -2^(DATA_W-1).
- Stored value without saturation is acc[DATA_W-1:0] (wrap).
- Latency: done is high in the cycle following the size^2*(size+1)-th rising edge after the start-sampling edge. This is 150 for size 5, 12 for size 2 and 2 for size 1.
- Elements with row or column >= size stay 0.
- start while busy is ignored and does not queue. start held high continuously begins a new operation on the first IDLE cycle after DONE.
- Input changes after the accepted start do not affect the result.

Optional Feature:
- Macro: ALU_MATMUL_SAT_EN.
- Defined: in WRITE, an overflowing element is clamped to 2^(DATA_W-1)-1 or -2^(DATA_W-1); overflow_flag is still raised.
- Undefined: overflowing elements wrap to the low DATA_W bits.

Decomposition:
- Shared package alu_pkg holds:
  - the FSM state encoding (IDLE, MAC, WRITE, DONE);
  - the ACC_W derivation;
  - an element index/offset helper (r*DIM+c)*DATA_W;
  - saturation-limit constants derived from DATA_W.
- One sub-module, alu_mac_unit. It is a signed DATA_W x DATA_W multiply plus ACC_W accumulate register with clear and enable, and contains no FSM.

Test Plan:
- size=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]], all other elements 0, overflow_flag=0, done exactly 12 edges after start, single-cycle done pulse.
- size=5, A=identity, B=random int8 -> C==B, overflow_flag=0, done at 150 edges, busy high throughout.
- size=5, A and B all 127 (acc=80645) -> wrap build: every element = 5, overflow_flag=1; ALU_MATMUL_SAT_EN build: every element = 127, overflow_flag=1.
- size=2, A all -128, B all 127 (acc=-32512) -> wrap build: elements 0, overflow_flag=1; saturation build: elements -128.
- start pulsed at cycles 3 and 40 of a size-5 operation and A_flat changed mid-run -> both pulses ignored, result reflects the latched operands, exactly one done.
- rst asserted at cycle 20 of an operation -> next cycle busy=0, C_flat=0, no done pulse. A fresh size-1 start with A=[3], B=[-4] -> C[0][0]=-12, done 2 edges later.
